// File: rtl/phv_seg_fifo.sv
// PHV buffer stored as lock-stepped SEG_WIDTH banks; registered FWFT output, parallel or segment-serial.
// One cycle write-to-valid latency; writes are never stalled: full without a pop drops and counts.
module phv_seg_fifo #(
    parameter int PHV_WIDTH  = 1124,
    parameter int SEG_WIDTH  = 512,
    parameter int DEPTH      = 32,
    parameter int NF_THRESH  = 4,
    parameter int SERIAL_OUT = 0,
    localparam int SEG_NUM   = (PHV_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH,
    localparam int OW        = (SERIAL_OUT != 0) ? SEG_WIDTH : PHV_WIDTH,
    localparam int SIW       = $clog2(SEG_NUM) + 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 flush,
    input  logic [PHV_WIDTH-1:0] phv_in,
    input  logic                 phv_in_valid,
    output logic [OW-1:0]        phv_out,
    output logic                 phv_out_valid,
    input  logic                 phv_out_ready,
    output logic [SIW-1:0]       phv_seg_idx,
    output logic                 phv_seg_last,
    output logic [CW-1:0]        count,
    output logic                 nearly_full,
    output logic                 full,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);
    localparam int PW = SEG_NUM * SEG_WIDTH;
    localparam int AW = $clog2(DEPTH);

    logic [PHV_WIDTH-1:0] mem [DEPTH];
    logic [PHV_WIDTH-1:0] head_q, head_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [SIW-1:0]       seg_q, seg_d;
    logic [15:0]          drop_q, drop_d;
    logic                 ovf_q, ovf_d;
    logic                 vld, last, beat, pop, wr_en, drop;

    assign vld   = (count_q != '0);
    assign last  = (SERIAL_OUT == 0) || (seg_q == SIW'(SEG_NUM - 1));
    assign beat  = vld && phv_out_ready;
    assign pop   = beat && last;
    assign full  = (count_q == CW'(DEPTH));
    assign nearly_full = ((CW'(DEPTH) - count_q) <= CW'(NF_THRESH));
    assign wr_en = phv_in_valid && !flush && (!full || pop);
    assign drop  = phv_in_valid && !flush && full && !pop;

    always_comb begin
        head_d   = head_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seg_d    = seg_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = rd_ptr_q;
            seg_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_en && !pop)      count_d = count_q + CW'(1);
            else if (!wr_en && pop) count_d = count_q - CW'(1);
            if (beat && SERIAL_OUT != 0) seg_d = last ? '0 : seg_q + SIW'(1);
            // Head register mirrors mem[rd_ptr]; bypass phv_in when the FIFO drains to it.
            if (pop) begin
                if (count_q > CW'(1)) head_d = mem[rd_ptr_q + AW'(1)];
                else if (wr_en)       head_d = phv_in;
            end else if (!vld && wr_en) begin
                head_d = phv_in;
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= phv_in;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seg_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seg_q    <= seg_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Bank padding above PHV_WIDTH is materialised only at the serial output mux.
    generate
        if (SERIAL_OUT != 0) begin : g_serial
            logic [PW-1:0] head_pad;
            assign head_pad = PW'(head_q);
            assign phv_out  = head_pad[int'(seg_q) * SEG_WIDTH +: SEG_WIDTH];
        end else begin : g_parallel
            assign phv_out = head_q;
        end
    endgenerate

    assign phv_out_valid = vld;
    assign phv_seg_last  = vld && last;
    assign phv_seg_idx   = seg_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_phv_seg_fifo.sv
// Bench for phv_seg_fifo: a parallel and a serial instance share write/flush stimulus and are
// compared every cycle against queue-based models, plus directed vectors and corner sequences.
module tb_phv_seg_fifo;
    localparam int PW = 1124;
    localparam int SW = 512;
    localparam int SN = 3;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic          flush = 1'b0;
    logic          vld = 1'b0;
    logic [PW-1:0] phv_in = '0;
    logic          p_rdy = 1'b0, s_rdy = 1'b0;

    logic [PW-1:0] p_out;
    logic [SW-1:0] s_out;
    logic          p_val, p_last, p_nf, p_full, p_ovf;
    logic          s_val, s_last, s_nf, s_full, s_ovf;
    logic [2:0]    p_idx, s_idx;
    logic [5:0]    p_cnt, s_cnt;
    logic [15:0]   p_drop, s_drop;

    always #5 clk = ~clk;

    phv_seg_fifo #(.PHV_WIDTH(PW), .SEG_WIDTH(SW), .DEPTH(D), .NF_THRESH(4), .SERIAL_OUT(0)) u_par (
        .clk(clk), .areset(areset), .flush(flush), .phv_in(phv_in), .phv_in_valid(vld),
        .phv_out(p_out), .phv_out_valid(p_val), .phv_out_ready(p_rdy), .phv_seg_idx(p_idx),
        .phv_seg_last(p_last), .count(p_cnt), .nearly_full(p_nf), .full(p_full),
        .overflow(p_ovf), .drop_cnt(p_drop));

    phv_seg_fifo #(.PHV_WIDTH(PW), .SEG_WIDTH(SW), .DEPTH(D), .NF_THRESH(4), .SERIAL_OUT(1)) u_ser (
        .clk(clk), .areset(areset), .flush(flush), .phv_in(phv_in), .phv_in_valid(vld),
        .phv_out(s_out), .phv_out_valid(s_val), .phv_out_ready(s_rdy), .phv_seg_idx(s_idx),
        .phv_seg_last(s_last), .count(s_cnt), .nearly_full(s_nf), .full(s_full),
        .overflow(s_ovf), .drop_cnt(s_drop));

    // Reference: parallel = queue of PHVs; serial = queue of beats (3 per PHV).
    typedef struct { logic [SW-1:0] d; int idx; } beat_t;
    logic [PW-1:0] pq[$];
    beat_t         sq[$];
    int            p_drops = 0, s_drops = 0;
    bit            p_of = 0, s_of = 0;
    int            n_chk = 0, n_fail = 0;

    typedef struct { bit fl; bit v; bit r; int ecnt; bit eval; } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [1535:0] a, input logic [1535:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            for (int w = 0; w < 48; w++) begin
                if (a[w*32 +: 32] !== e[w*32 +: 32]) begin
                    $display("FAIL %s: word %0d got %h expected %h", nm, w, a[w*32 +: 32], e[w*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [PW-1:0] rnd_phv();
        logic [1151:0] t;
        for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom();
        return t[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] pat_phv();
        logic [PW-1:0] t;
        for (int i = 0; i < PW / 4; i++) t[i*4 +: 4] = 4'((i % 15) + 1);
        return t;
    endfunction

    task automatic model_step();
        bit pp, pu, sb, sp, su;
        int se;
        logic [1535:0] pad;
        beat_t b;
        if (flush) begin
            pq.delete();
            sq.delete();
        end else begin
            pp = (pq.size() > 0) && p_rdy;
            pu = vld && ((pq.size() < D) || pp);
            if (vld && !pu) begin
                if (p_drops < 65535) p_drops++;
                p_of = 1;
            end
            if (pp) void'(pq.pop_front());
            if (pu) pq.push_back(phv_in);

            se = (sq.size() + SN - 1) / SN;
            sb = (sq.size() > 0) && s_rdy;
            sp = sb && (sq[0].idx == SN - 1);
            su = vld && ((se < D) || sp);
            if (vld && !su) begin
                if (s_drops < 65535) s_drops++;
                s_of = 1;
            end
            if (sb) void'(sq.pop_front());
            if (su) begin
                pad = '0;
                pad[PW-1:0] = phv_in;
                for (int k = 0; k < SN; k++) begin
                    b.d = pad[k*SW +: SW];
                    b.idx = k;
                    sq.push_back(b);
                end
            end
        end
    endtask

    task automatic check_all();
        int ps, ss;
        ps = pq.size();
        ss = sq.size();
        chk("p_valid", p_val, ps > 0);
        chk("p_count", p_cnt, ps);
        chk("p_full", p_full, ps == D);
        chk("p_nearly_full", p_nf, (D - ps) <= 4);
        chk("p_seg_last", p_last, ps > 0);
        chk("p_seg_idx", p_idx, 0);
        chk("p_drop_cnt", p_drop, p_drops);
        chk("p_overflow", p_ovf, p_of);
        if (ps > 0) chk_w("p_data", p_out, pq[0]);
        chk("s_valid", s_val, ss > 0);
        chk("s_count", s_cnt, (ss + SN - 1) / SN);
        chk("s_full", s_full, ((ss + SN - 1) / SN) == D);
        chk("s_nearly_full", s_nf, (D - (ss + SN - 1) / SN) <= 4);
        chk("s_seg_idx", s_idx, (ss > 0) ? sq[0].idx : 0);
        chk("s_seg_last", s_last, (ss > 0) && (sq[0].idx == SN - 1));
        chk("s_drop_cnt", s_drop, s_drops);
        chk("s_overflow", s_ovf, s_of);
        if (ss > 0) chk_w("s_data", s_out, sq[0].d);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic chk_zero(input string tag);
        chk_w({tag, "_p_out"}, p_out, '0);
        chk({tag, "_p_valid"}, p_val, 0);
        chk({tag, "_p_idx"}, p_idx, 0);
        chk({tag, "_p_last"}, p_last, 0);
        chk({tag, "_p_count"}, p_cnt, 0);
        chk({tag, "_p_full"}, p_full, 0);
        chk({tag, "_p_nf"}, p_nf, 0);
        chk({tag, "_p_ovf"}, p_ovf, 0);
        chk({tag, "_p_drop"}, p_drop, 0);
        chk_w({tag, "_s_out"}, s_out, '0);
        chk({tag, "_s_valid"}, s_val, 0);
        chk({tag, "_s_idx"}, s_idx, 0);
        chk({tag, "_s_last"}, s_last, 0);
        chk({tag, "_s_count"}, s_cnt, 0);
        chk({tag, "_s_full"}, s_full, 0);
        chk({tag, "_s_nf"}, s_nf, 0);
        chk({tag, "_s_ovf"}, s_ovf, 0);
        chk({tag, "_s_drop"}, s_drop, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] pat, last_phv;
        bit seen;
        int run, best;

        // {flush, write, ready, expected count, expected valid} for the parallel instance
        tbl[0]  = '{0, 1, 1, 1, 1};
        tbl[1]  = '{0, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 1};
        tbl[3]  = '{0, 1, 0, 2, 1};
        tbl[4]  = '{0, 1, 0, 3, 1};
        tbl[5]  = '{0, 1, 0, 4, 1};
        tbl[6]  = '{0, 1, 0, 5, 1};
        tbl[7]  = '{1, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 1, 1, 1};
        tbl[9]  = '{0, 1, 1, 1, 1};
        tbl[10] = '{0, 0, 1, 0, 0};
        pat = pat_phv();

        #2 areset = 1'b1;
        #20;
        chk_zero("reset");
        areset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            flush = tbl[i].fl;
            vld   = tbl[i].v;
            p_rdy = tbl[i].r;
            s_rdy = tbl[i].r;
            phv_in = (i == 0) ? pat : rnd_phv();
            tick();
            chk($sformatf("tbl%0d_count", i), p_cnt, tbl[i].ecnt);
            chk($sformatf("tbl%0d_valid", i), p_val, tbl[i].eval);
            chk($sformatf("tbl%0d_drop", i), p_drop, 0);
            if (i == 0) chk_w("t1_pattern", p_out, pat);
        end
        flush = 0; vld = 0; p_rdy = 1; s_rdy = 1;
        for (int i = 0; i < 8; i++) tick();

        // Fill with no reader, then overflow by three
        p_rdy = 0; s_rdy = 0; vld = 1;
        for (int i = 0; i < D; i++) begin
            phv_in = rnd_phv();
            tick();
            chk("t2_nearly_full", p_nf, (i + 1) >= 28);
            chk("t2_full", p_full, i == D - 1);
        end
        for (int i = 0; i < 3; i++) begin
            phv_in = rnd_phv();
            tick();
        end
        chk("t2_drop3", p_drop, 3);
        chk("t2_ovf", p_ovf, 1);
        chk("t2_s_drop3", s_drop, 3);

        // Full with concurrent write and pop
        last_phv = rnd_phv();
        phv_in = last_phv; p_rdy = 1;
        tick();
        chk("t3_count32", p_cnt, 32);
        chk("t3_drop_same", p_drop, 3);
        vld = 0; s_rdy = 1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (p_val && p_cnt == 1) begin
                chk_w("t3_last_out", p_out, last_phv);
                seen = 1;
            end
            tick();
        end
        chk("t3_last_seen", seen, 1);

        // Serial back-to-back: two PHVs -> six consecutive beats
        s_rdy = 1; p_rdy = 1; run = 0; best = 0;
        for (int i = 0; i < 10; i++) begin
            vld = (i < 2);
            phv_in = rnd_phv();
            tick();
            if (s_val && s_idx == 2) chk_w("t4_pad", s_out[511:100], '0);
            run = s_val ? run + 1 : 0;
            if (run > best) best = run;
        end
        chk("t4_consecutive", best, 6);

        // Serial with ready toggling 1010..
        for (int i = 0; i < 16; i++) begin
            vld = (i < 2);
            phv_in = rnd_phv();
            s_rdy = (i % 2 == 0);
            tick();
        end

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            vld   = $urandom_range(0, 99) < 60;
            p_rdy = $urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 90 : 30);
            s_rdy = $urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 95 : 60);
            flush = $urandom_range(0, 79) == 0;
            phv_in = rnd_phv();
            tick();
        end

        // Async reset in the middle of a serial PHV
        flush = 1; vld = 0;
        tick();
        flush = 0; vld = 1; phv_in = rnd_phv(); s_rdy = 0; p_rdy = 0;
        tick();
        vld = 0; s_rdy = 1;
        tick();
        s_rdy = 0;
        chk("t6_pre_idx", s_idx, 1);
        #2 areset = 1'b1;
        #1;
        pq.delete(); sq.delete();
        p_drops = 0; s_drops = 0; p_of = 0; s_of = 0;
        chk_zero("t6_reset");
        #2 areset = 1'b0;
        vld = 1; phv_in = rnd_phv();
        tick();
        chk("t6_idx0", s_idx, 0);
        chk("t6_valid", s_val, 1);
        vld = 0; s_rdy = 1; p_rdy = 1;
        for (int i = 0; i < 5; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
